// File: rtl/nfca_rx_demodulate.sv
// NFC-A card-response demodulator: Manchester on the 847.5 kHz subcarrier at 106 kbit/s.
// Optional collision reporting is enabled by defining NFCA_RX_COLLISION_EN (adds rx_col, rx_col_pos).
module nfca_rx_demodulate #(
  parameter int HALF_BIT_CLK = 384,
  parameter int PRESENT_TH   = 2,
  parameter int MAX_BITS     = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_on,
  input  logic       rx_lm,
  output logic       rx_bit_en,
  output logic       rx_bit,
  output logic       rx_end,
  output logic       rx_err,
  output logic [9:0] rx_bit_cnt,
`ifdef NFCA_RX_COLLISION_EN
  output logic       rx_col,
  output logic [9:0] rx_col_pos,
`endif
  output logic       busy
);

  localparam int HW = $clog2(HALF_BIT_CLK);

  typedef enum logic [1:0] {IDLE, HUNT, RECV, DONE} state_t;

  state_t        state, state_next;
  logic          s1, s2, s3;
  logic          edge_det;
  logic [HW-1:0] hcnt;
  logic          half;
  logic [7:0]    ecnt;
  logic          h1;
  logic          sof;
  logic          half_end;
  logic [8:0]    esum;
  logic          present_now;
  logic          start, sof_clr, bit_fire, bit_val, end_fire, end_err, col_fire;

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rx_lm;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det    = s2 & ~s3;
  assign half_end    = (state == RECV) && (hcnt == HW'(HALF_BIT_CLK - 1));
  // The edge landing on the last cycle of a half still counts for that half.
  assign esum        = {1'b0, ecnt} + {8'd0, edge_det};
  assign present_now = (esum >= 9'(PRESENT_TH));
  assign busy        = (state == RECV);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    sof_clr    = 1'b0;
    bit_fire   = 1'b0;
    bit_val    = 1'b0;
    end_fire   = 1'b0;
    end_err    = 1'b0;
    col_fire   = 1'b0;
    unique case (state)
      IDLE: if (rx_on) state_next = HUNT;
      HUNT: begin
        if (!rx_on) state_next = IDLE;
        else if (edge_det) begin
          state_next = RECV;
          start      = 1'b1;
        end
      end
      RECV: begin
        // Losing the window beats any decision falling on the same cycle.
        if (!rx_on) begin
          state_next = IDLE;
          end_fire   = 1'b1;
          end_err    = 1'b1;
        end else if (half_end && half) begin
          if (sof) begin
            if (h1 && !present_now) sof_clr = 1'b1;
            else begin
              end_fire   = 1'b1;
              end_err    = 1'b1;
              state_next = DONE;
            end
          end else begin
            unique case ({h1, present_now})
              2'b00: begin
                end_fire   = 1'b1;
                end_err    = (rx_bit_cnt == 10'd0);
                state_next = DONE;
              end
              2'b11: begin
`ifdef NFCA_RX_COLLISION_EN
                bit_fire = 1'b1;
                bit_val  = 1'b1;
                col_fire = 1'b1;
`else
                end_fire   = 1'b1;
                end_err    = 1'b1;
                state_next = DONE;
`endif
              end
              default: begin
                bit_fire = 1'b1;
                bit_val  = h1;
              end
            endcase
            if (bit_fire && (rx_bit_cnt == 10'(MAX_BITS))) begin
              bit_fire   = 1'b0;
              col_fire   = 1'b0;
              end_fire   = 1'b1;
              end_err    = 1'b1;
              state_next = DONE;
            end
          end
        end
      end
      DONE: if (!rx_on) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_bit_en  <= 1'b0;
      rx_bit     <= 1'b0;
      rx_end     <= 1'b0;
      rx_err     <= 1'b0;
      rx_bit_cnt <= '0;
      hcnt       <= '0;
      half       <= 1'b0;
      ecnt       <= '0;
      h1         <= 1'b0;
      sof        <= 1'b0;
    end else begin
      rx_bit_en <= bit_fire;
      rx_bit    <= bit_fire & bit_val;
      rx_end    <= end_fire;
      rx_err    <= end_fire & end_err;
      if (start) begin
        hcnt       <= '0;
        half       <= 1'b0;
        ecnt       <= 8'd1;
        sof        <= 1'b1;
        rx_bit_cnt <= '0;
      end else if (state == RECV) begin
        if (half_end) begin
          hcnt <= '0;
          half <= ~half;
          ecnt <= '0;
        end else begin
          hcnt <= hcnt + HW'(1);
          if (ecnt != 8'hFF) ecnt <= ecnt + {7'd0, edge_det};
        end
        if (half_end && !half) h1 <= present_now;
        if (sof_clr) sof <= 1'b0;
        if (bit_fire) rx_bit_cnt <= rx_bit_cnt + 10'd1;
      end
    end
  end

`ifdef NFCA_RX_COLLISION_EN
  logic col_seen;

  // Only the first collision of a frame is latched; rx_col_pos holds afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_col     <= 1'b0;
      rx_col_pos <= '0;
      col_seen   <= 1'b0;
    end else begin
      rx_col <= col_fire;
      if (start) col_seen <= 1'b0;
      else if (col_fire && !col_seen) begin
        col_seen   <= 1'b1;
        rx_col_pos <= rx_bit_cnt;
      end
    end
  end
`endif

endmodule
